serial_pattern_scheduler: RTL and testbench
===========================================

# serial_pattern_scheduler

Word-level controller that sequences a serial 4-bit pattern matcher. It accepts parallel words over a valid/ready handshake and shifts each word MSB-first into a programmable pattern window at one bit per clock. It reports per-bit hit pulses and a per-word match count. It sits between a parallel producer and any logic that consumes serial-detect results.

## Interface
- DW, 16, data word width (≥ PW)
- PW, 4, pattern length in bits
- CW, 8, match counter width
- RST_PAT, 4'b1010, pattern register reset value
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  pattern write strobe; honoured only in IDLE
- cfg_pat  in  PW  new pattern
- in_valid  in  1  word available
- in_ready  out  1  block can accept a word (high only in IDLE)
- in_data  in  DW  word to scan, MSB scanned first
- ser_bit  out  1  last bit shifted into the window (registered)
- hit  out  1  one-cycle pulse: window equals pattern
- done  out  1  one-cycle pulse: word fully scanned, match_cnt final
- match_cnt  out  CW  matches in current/last word
- busy  out  1  high in SHIFT and DONE

## Operation
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data into the shift register, clear the window fill count, bit index and match_cnt, then go to SHIFT.
  - SHIFT: each cycle, shift the MSB out into window = {window[PW-2:0], bit}, increment the fill count (saturating at PW) and the bit index. After bit DW-1, go to DONE.
  - DONE: stays one cycle, then returns to IDLE.
- Match: registered compare of the updated window against the pattern register, qualified by fill count ≥ PW. On a match, pulse hit and increment match_cnt; match_cnt saturates at 2^CW-1.
- Window state never carries across words.
- cfg_we in IDLE writes the pattern register. cfg_we simultaneous with an accepted word: the pattern is written on the same edge, and that word is scanned with the new pattern. cfg_we outside IDLE is ignored.
- match_cnt holds its value after DONE until the next word is accepted.
- Reset values: in_ready=0 during reset, 1 after release (IDLE). ser_bit=0, hit=0, done=0, match_cnt=0, busy=0, pattern=RST_PAT, window/fill count cleared.
- Reset asserted mid-word: the word is discarded, no done pulse, all outputs take reset values immediately.

## Timing
- Word accepted at edge 0; bit i (i=0 is the MSB) is shifted at edge i+1. ser_bit, hit and match_cnt update at the same edge.
- First possible hit: edge PW (bit PW-1).
- Last bit at edge DW; done=1, busy=1 for the cycle after edge DW; IDLE with in_ready=1 after edge DW+1.
- Throughput: one word per DW+2 cycles. in_ready is combinational from state only, never from in_valid.
- Without a handshake, in_data is not sampled.

## Configuration
- OVERLAP_EN defined: the window is retained after a match, so overlapping matches count (1010 in 101010 gives 2).
- OVERLAP_EN undefined: the fill count clears on a match, so the next match needs PW fresh bits (101010 gives 1).
- No other behaviour differs.

## Test plan
- Reset release, no traffic -> in_ready=1, busy=0, hit=0, done=0, match_cnt=0, pattern 1010.
- Default pattern, word 16'hA5A5 -> hits at edges 4 and 12, done during the cycle after edge 16, match_cnt=2 in both configurations.
- Word 16'hAAAA -> with OVERLAP_EN: 7 hits at edges 4, 6, …, 16, match_cnt=7. Without: hits at edges 4, 8, 12, 16, match_cnt=4.
- cfg_we=1 with cfg_pat=4'b1111 simultaneous with accept of 16'hFFFF -> match_cnt=13 (OVERLAP_EN) or 4 (undefined). A later cfg_we=1 with cfg_pat=4'b0000 while busy is ignored; the next 16'h0000 word gives 0 hits.
- in_valid held high back-to-back with words 16'hAAAA then 16'h0000 -> second accept exactly DW+2 cycles after the first, match_cnt clears to 0 on the second accept and stays 0.
- rst pulsed low at edge 8 of a 16'hAAAA scan -> outputs at reset values immediately, no done pulse. The next word 16'hA5A5 scans cleanly with match_cnt=2.

Source files
------------

// File: rtl/serial_pattern_scheduler.sv
// Accepts a word, scans it MSB-first through a PW-bit window one bit per clock, and pulses hit and counts matches.
// Define OVERLAP_EN to keep the window after a match so that overlapping matches are also counted.
module serial_pattern_scheduler #(
    parameter int              DW      = 16,
    parameter int              PW      = 4,
    parameter int              CW      = 8,
    parameter logic [PW-1:0]   RST_PAT = 4'b1010
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cfg_we_i,
    input  logic [PW-1:0] cfg_pat_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          ser_bit_o,
    output logic          hit_o,
    output logic          done_o,
    output logic [CW-1:0] match_cnt_o,
    output logic          busy_o
);
    localparam int FW = $clog2(PW + 1);
    localparam int IW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e        state_q;
    logic [DW-1:0] sh_q;
    logic [PW-1:0] win_q;
    logic [PW-1:0] pat_q;
    logic [FW-1:0] fill_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] cnt_q;
    logic          ser_q;
    logic          hit_q;
    logic          done_q;

    logic [PW-1:0] win_d;
    logic [FW-1:0] fill_d;
    logic          match_d;
    logic          accept;

    // Ready depends on state only; forced low while reset is held.
    assign in_ready_o  = rst_ni && (state_q == IDLE);
    assign accept      = in_valid_i && in_ready_o;
    assign busy_o      = (state_q != IDLE);
    assign ser_bit_o   = ser_q;
    assign hit_o       = hit_q;
    assign done_o      = done_q;
    assign match_cnt_o = cnt_q;

    always_comb begin
        win_d   = {win_q[PW-2:0], sh_q[DW-1]};
        fill_d  = (fill_q == FW'(PW)) ? fill_q : fill_q + 1'b1;
        match_d = (state_q == SHIFT) && (win_d == pat_q) && (fill_d == FW'(PW));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sh_q    <= '0;
            win_q   <= '0;
            pat_q   <= RST_PAT;
            fill_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_we_i) pat_q <= cfg_pat_i;
                    if (accept) begin
                        sh_q    <= in_data_i;
                        win_q   <= '0;
                        fill_q  <= '0;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_q  <= {sh_q[DW-2:0], 1'b0};
                    win_q <= win_d;
                    ser_q <= sh_q[DW-1];
                    idx_q <= idx_q + 1'b1;
                    hit_q <= match_d;
`ifdef OVERLAP_EN
                    fill_q <= fill_d;
`else
                    // A match consumes the window; the next one needs PW fresh bits.
                    fill_q <= match_d ? '0 : fill_d;
`endif
                    if (match_d && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
                    if (idx_q == IW'(DW - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_pattern_scheduler.sv
// Directed plus randomized bench for serial_pattern_scheduler against a bit-string match model.
module tb_serial_pattern_scheduler;
    localparam int DW = 16;
    localparam int PW = 4;
    localparam int CW = 8;
`ifdef OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [PW-1:0] cfg_pat;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          ser_bit;
    logic          hit;
    logic          done;
    logic [CW-1:0] match_cnt;
    logic          busy;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            last_cnt = 0;
    logic [PW-1:0] mpat;

    serial_pattern_scheduler #(.DW(DW), .PW(PW), .CW(CW), .RST_PAT(4'b1010)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cfg_we_i   (cfg_we),
        .cfg_pat_i  (cfg_pat),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .ser_bit_o  (ser_bit),
        .hit_o      (hit),
        .done_o     (done),
        .match_cnt_o(match_cnt),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scan order bit j is w[DW-1-j]; a match ends at bit i when the PW bits ending there equal pat.
    // Without overlap, a match may not reuse any bit of the previous match.
    function automatic void model(input logic [DW-1:0] w, input logic [PW-1:0] pat,
                                  output logic [DW-1:0] hv, output int n);
        int last;
        last = -1;
        n    = 0;
        hv   = '0;
        for (int i = PW - 1; i < DW; i++) begin
            logic [PW-1:0] win;
            for (int k = 0; k < PW; k++) win[PW-1-k] = w[DW-1-(i-PW+1+k)];
            if (win == pat && (OVL || (i - PW + 1) > last)) begin
                hv[i] = 1'b1;
                n++;
                last = i;
            end
        end
        if (n > (1 << CW) - 1) n = (1 << CW) - 1;
    endfunction

    task automatic run_word(input logic [DW-1:0] w, input logic we, input logic [PW-1:0] p,
                            input logic keep_valid, input logic busy_cfg);
        logic [DW-1:0] hv;
        int n;
        int run;
        chk("rdy_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = w;
        cfg_we   = we;
        cfg_pat  = p;
        if (we) mpat = p;
        model(w, mpat, hv, n);
        @(posedge clk); #1;
        acc_cyc  = cyc;
        cfg_we   = 1'b0;
        in_valid = keep_valid;
        in_data  = ~w;
        chk("accept_busy", busy, 1);
        chk("accept_rdy", in_ready, 0);
        chk("accept_cnt_clear", match_cnt, 0);
        chk("accept_hit", hit, 0);
        run = 0;
        for (int i = 0; i < DW; i++) begin
            if (busy_cfg && i == 2) begin
                cfg_we  = 1'b1;
                cfg_pat = ~mpat;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            if (hv[i]) run++;
            chk("ser_bit", ser_bit, w[DW-1-i]);
            chk("hit", hit, hv[i]);
            chk("match_cnt_run", match_cnt, run);
            chk("done_timing", done, (i == DW - 1));
        end
        chk("done_busy", busy, 1);
        chk("done_rdy", in_ready, 0);
        chk("final_cnt", match_cnt, n);
        @(posedge clk); #1;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_hit", hit, 0);
        chk("post_rdy", in_ready, 1);
        chk("cnt_held", match_cnt, n);
        last_cnt = n;
    endtask

    initial begin
        logic [DW-1:0] hv;
        int n;
        int a1;
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_pat  = '0;
        in_valid = 1'b0;
        in_data  = '0;
        mpat     = 4'b1010;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hit", hit, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_ser", ser_bit, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", in_ready, 1);
        @(posedge clk); #1;
        chk("idle_rdy", in_ready, 1);
        chk("idle_busy", busy, 0);

        // Default pattern checks and overlap behaviour.
        run_word(16'hA5A5, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("a5a5_cnt", last_cnt, 2);
        run_word(16'hAAAA, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("aaaa_cnt", last_cnt, OVL ? 7 : 4);

        // Pattern write with accept, then an ignored write while busy.
        run_word(16'hFFFF, 1'b1, 4'b1111, 1'b0, 1'b1);
        chk("ffff_cnt", last_cnt, OVL ? 13 : 4);
        run_word(16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("zero_cnt", last_cnt, 0);

        // Back-to-back with in_valid held high.
        run_word(16'hAAAA, 1'b1, 4'b1010, 1'b1, 1'b0);
        a1 = acc_cyc;
        run_word(16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("b2b_spacing", acc_cyc - a1, DW + 2);
        chk("b2b_cnt", last_cnt, 0);

        // Reset in the middle of a word; pattern returns to its reset value.
        in_valid = 1'b1;
        in_data  = 16'hAAAA;
        cfg_we   = 1'b1;
        cfg_pat  = 4'b0110;
        mpat     = 4'b0110;
        model(16'hAAAA, mpat, hv, n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("mid_hit", hit, hv[i]);
        end
        rst_n = 1'b0;
        mpat  = 4'b1010;
        #1;
        chk("midrst_rdy", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_hit", hit, 0);
        chk("midrst_done", done, 0);
        chk("midrst_cnt", match_cnt, 0);
        chk("midrst_ser", ser_bit, 0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("midrst_no_done", done, 0);
            chk("midrst_hold_busy", busy, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_rdy", in_ready, 1);
        run_word(16'hA5A5, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("after_rst_cnt", last_cnt, 2);

        // Randomized words, patterns, idle gaps and busy-time writes.
        for (int t = 0; t < 24; t++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                in_data = DW'($urandom);
                @(posedge clk); #1;
                chk("gap_rdy", in_ready, 1);
                chk("gap_busy", busy, 0);
                chk("gap_cnt", match_cnt, last_cnt);
            end
            run_word(DW'($urandom), 1'($urandom), PW'($urandom), 1'b0, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
